// File: rtl/soc2_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package  : soc2_mem_pkg
// Brief    : Shared types and constants for the OBI memory bridge.
// Revision : 1.0
// ============================================================================
package soc2_mem_pkg;

    localparam int unsigned c_FIFO_DEPTH = 2;
    localparam int unsigned c_FIFO_PTR_W = $clog2(c_FIFO_DEPTH);
    localparam int unsigned c_FIFO_CNT_W = $clog2(c_FIFO_DEPTH + 1);
    localparam int unsigned c_DEF_DATA_W = 32;

    // Response entry for the default 32-bit word; wider builds supply their own.
    typedef struct packed {
        logic [c_DEF_DATA_W-1:0] rdata;
        logic                    err;
    } resp_entry_t;

    function automatic int unsigned calc_aw(input int unsigned word_size_byte,
                                            input int unsigned size_in_kb);
        return $clog2(size_in_kb * 1024 / word_size_byte) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/obi_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : obi_resp_fifo
// Brief    : 2-entry response FIFO; push and pop in the same cycle are legal.
// Revision : 1.0
// ============================================================================
module obi_resp_fifo
    import soc2_mem_pkg::*;
#(
    parameter type entry_t = resp_entry_t
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  entry_t                  data_i,
    input  logic                    pop_i,
    output entry_t                  data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [c_FIFO_CNT_W-1:0] count_o
);

    entry_t                  mem_q [c_FIFO_DEPTH];
    logic [c_FIFO_PTR_W-1:0] wptr_q, wptr_d;
    logic [c_FIFO_PTR_W-1:0] rptr_q, rptr_d;
    logic [c_FIFO_CNT_W-1:0] count_q, count_d;
    logic                    w_do_push;
    logic                    w_do_pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == c_FIFO_CNT_W'(c_FIFO_DEPTH));
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign data_o    = mem_q[rptr_q];
    assign count_o   = count_q;

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (w_do_push) wptr_d = wptr_q + c_FIFO_PTR_W'(1);
        if (w_do_pop)  rptr_d = rptr_q + c_FIFO_PTR_W'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + c_FIFO_CNT_W'(1);
            2'b01:   count_d = count_q - c_FIFO_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) mem_q[wptr_q] <= data_i;
    end

endmodule
`default_nettype wire

// File: rtl/obi_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : obi_mem_bridge
// Brief    : OBI slave to single-port memory bridge, in-order responses via a
//            2-entry FIFO. Optional check macro: OBI_MEM_BRIDGE_ADDR_CHECK_EN.
// Revision : 1.0
// ============================================================================
module obi_mem_bridge
    import soc2_mem_pkg::*;
#(
    parameter  int unsigned WORD_SIZE_BYTE = 4,
    parameter  int unsigned SIZE_IN_KB     = 8,
    parameter  logic [31:0] BASE_ADDR      = 32'h0000_0000,
    localparam int unsigned AW             = calc_aw(WORD_SIZE_BYTE, SIZE_IN_KB),
    localparam int unsigned DW             = WORD_SIZE_BYTE * 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [31:0]               addr_i,
    input  logic                      we_i,
    input  logic [WORD_SIZE_BYTE-1:0] be_i,
    input  logic [DW-1:0]             wdata_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [DW-1:0]             rdata_o,
    output logic                      err_o,
    output logic                      mem_ena_o,
    output logic [AW-1:0]             mem_addr_o,
    output logic [WORD_SIZE_BYTE-1:0] mem_wea_o,
    output logic [DW-1:0]             mem_dina_o,
    input  logic [DW-1:0]             mem_douta_i
);

    localparam int unsigned c_OFF_BITS = $clog2(WORD_SIZE_BYTE);

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } resp_t;

    logic                    p_valid_q, p_valid_d;
    logic                    p_we_q, p_we_d;
    logic                    p_err_q, p_err_d;
    logic [31:0]             w_offset;
    logic                    w_addr_err;
    logic                    w_mem_en;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_full;
    logic                    w_empty;
    logic [c_FIFO_CNT_W-1:0] w_count;
    logic [2:0]              w_pend;
    resp_t                   w_push_entry;
    resp_t                   w_head;

    assign w_offset = addr_i - BASE_ADDR;

`ifdef OBI_MEM_BRIDGE_ADDR_CHECK_EN
    localparam logic [32:0] c_MEM_BYTES  = 33'(SIZE_IN_KB) * 33'd1024;
    localparam logic [31:0] c_ALIGN_MASK = 32'(WORD_SIZE_BYTE - 1);

    assign w_addr_err = (addr_i < BASE_ADDR)
                      | ({1'b0, w_offset} >= c_MEM_BYTES)
                      | ((addr_i & c_ALIGN_MASK) != 32'd0);
`else
    assign w_addr_err = 1'b0;
`endif

    // Outstanding = in the memory pipe + queued; a same-cycle pop frees a slot.
    assign w_pop  = rvalid_o & rready_i;
    assign w_pend = 3'(p_valid_q) + 3'(w_count) - 3'(w_pop);
    assign gnt_o  = req_i & ~rst_i & (w_pend < 3'd2);

    assign w_mem_en   = gnt_o & ~w_addr_err;
    assign mem_ena_o  = w_mem_en;
    assign mem_wea_o  = (w_mem_en & we_i) ? be_i : '0;
    assign mem_addr_o = AW'(w_offset >> c_OFF_BITS);
    assign mem_dina_o = wdata_i;

    always_comb begin
        p_valid_d = gnt_o;
        p_we_d    = we_i;
        p_err_d   = w_addr_err;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_valid_q <= 1'b0;
            p_we_q    <= 1'b0;
            p_err_q   <= 1'b0;
        end else begin
            p_valid_q <= p_valid_d;
            p_we_q    <= p_we_d;
            p_err_q   <= p_err_d;
        end
    end

    // Writes and rejected accesses return zero data; memory data is valid now.
    assign w_push_entry.rdata = (p_we_q | p_err_q) ? '0 : mem_douta_i;
    assign w_push_entry.err   = p_err_q;
    assign w_push             = p_valid_q & (~w_full | w_pop);

    obi_resp_fifo #(
        .entry_t (resp_t)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign rvalid_o = ~w_empty;
    assign rdata_o  = w_empty ? '0 : w_head.rdata;
    assign err_o    = ~w_empty & w_head.err;

endmodule
`default_nettype wire

// File: doc/obi_mem_bridge.md
OBI_MEM_BRIDGE -- requirements
Module: obi_mem_bridge

Interface
REQ-001 Parameter WORD_SIZE_BYTE, default 4, memory word width in bytes.
REQ-002 Parameter SIZE_IN_KB, default 8, memory size; DEPTH = SIZE_IN_KB*1024/WORD_SIZE_BYTE; AW = $clog2(DEPTH)+1.
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-004 clk_i  in  1  single clock, rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  1  core request valid.
REQ-007 gnt_o  out  1  request accepted this cycle.
REQ-008 addr_i  in  32  byte address.
REQ-009 we_i  in  1  1 = write, 0 = read.
REQ-010 be_i  in  WORD_SIZE_BYTE  byte enables.
REQ-011 wdata_i  in  WORD_SIZE_BYTE*8  write data.
REQ-012 rvalid_o  out  1  response valid.
REQ-013 rready_i  in  1  core accepts response.
REQ-014 rdata_o  out  WORD_SIZE_BYTE*8  read data; 0 for write responses.
REQ-015 err_o  out  1  response error flag.
REQ-016 mem_ena_o / mem_addr_o[AW] / mem_wea_o[WORD_SIZE_BYTE] / mem_dina_o  out  drive memory port A (ena, addra, wea, dina).
REQ-017 mem_douta_i  in  WORD_SIZE_BYTE*8  memory read data, valid one cycle after a read enable.

Function
REQ-018 Outstanding count OC = p_valid + fifo_count; gnt_o = req_i & (OC - pop < 2), pop = rvalid_o & rready_i (combinational rready_i -> gnt_o path permitted).
REQ-019 On grant at cycle N: mem_ena_o=1, mem_addr_o=(addr_i-BASE_ADDR)>>log2(WORD_SIZE_BYTE) truncated to AW bits, mem_wea_o = we_i ? be_i : 0, mem_dina_o=wdata_i, all combinational in cycle N.
REQ-020 Without grant: mem_ena_o=0, mem_wea_o=0; mem_addr_o/mem_dina_o don't-care.
REQ-021 Pipe stage registers p_valid, p_we, p_err at N; at N+1 a response {rdata = p_we ? 0 : mem_douta_i, err = p_err} is pushed into a 2-entry FIFO.
REQ-022 rvalid_o = FIFO non-empty; rdata_o/err_o = FIFO head; minimum latency grant->rvalid_o = 2 cycles.
REQ-023 Responses are returned strictly in request order.
REQ-024 Simultaneous push and pop on a full or empty FIFO is legal; count unchanged when both occur, head advances.
REQ-025 With rready_i held 1, back-to-back requests are granted every cycle (throughput 1/cycle).
REQ-026 With rready_i held 0, at most 2 requests are granted; gnt_o stays 0 until a pop.
REQ-027 rvalid_o, rdata_o, err_o remain stable while rvalid_o=1 and rready_i=0.
REQ-028 be_i=0 on a write is granted, writes nothing, returns a normal write response.

Reset
REQ-029 rst_i asserted clears p_valid, FIFO pointers and count immediately; rvalid_o=0, err_o=0, rdata_o=0, gnt_o=0, mem_ena_o=0, mem_wea_o=0.
REQ-030 Reset mid-transaction drops all in-flight responses; memory contents are untouched by the bridge after rst_i assertion.
REQ-031 First grant possible in the first cycle after rst_i deasserts.

Configuration
REQ-032 Macro OBI_MEM_BRIDGE_ADDR_CHECK_EN: when defined, addr_i outside [BASE_ADDR, BASE_ADDR+SIZE_IN_KB*1024) or not word-aligned is granted, mem_ena_o=0, and the response has err_o=1, rdata_o=0.
REQ-033 When undefined: no check, err_o tied 0, index wraps modulo 2^AW.

Structure
REQ-034 Package soc2_mem_pkg holds the response-entry struct typedef (rdata, err), FIFO depth constant (2) and a function computing AW from WORD_SIZE_BYTE/SIZE_IN_KB.
REQ-035 The 2-entry response FIFO is sub-module obi_resp_fifo (push/pop/full/empty/count, async active-high reset).

Verification
REQ-036 Read after reset: memory preloaded word 5 = 32'hDEAD_BEEF; read addr 32'h14 granted at N -> rvalid_o=1 at N+2, rdata_o=32'hDEAD_BEEF, err_o=0.
REQ-037 Byte write: write addr 32'h8, be_i=4'b0010, wdata_i=32'h0000_AB00 over word 32'h1122_3344, then read 32'h8 -> rdata_o=32'h1122_AB44.
REQ-038 Backpressure: rready_i=0, 4 back-to-back reads -> exactly 2 grants; release rready_i -> remaining 2 granted, 4 responses in order.
REQ-039 Streaming: rready_i=1, 8 consecutive reads -> gnt_o=1 every cycle, 8 responses on consecutive cycles.
REQ-040 With OBI_MEM_BRIDGE_ADDR_CHECK_EN, SIZE_IN_KB=8: read addr 32'h2000 -> mem_ena_o=0, response err_o=1, rdata_o=0; addr 32'h2 -> err_o=1.
REQ-041 Reset mid-op: 2 responses pending, rst_i pulsed -> rvalid_o=0 same cycle, no stale response after release.
